hqc_encap_out_streamer: RTL and testbench



---
 rtl/hqc_encap_out_streamer_pkg.sv | 48 ++++
 rtl/hqc_encap_out_streamer_fifo2.sv | 60 ++++++
 rtl/hqc_encap_out_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_hqc_encap_out_streamer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_encap_out_streamer_pkg.sv
// Shared definitions for the HQC encapsulation output streamer.
//   - Section-type codes as driven on encap_out_type / out_sect.
//   - FSM state encoding (also exported on the debug port).
//   - Per-parameter-set code length and memory word count.
//   - Byte-reversal helpers used on the read-data path.
package hqc_encap_out_streamer_pkg;

  localparam logic [1:0] SECT_SS = 2'd0;
  localparam logic [1:0] SECT_D  = 2'd1;
  localparam logic [1:0] SECT_U  = 2'd2;
  localparam logic [1:0] SECT_V  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_U  = 3'd1,
    ST_RD_V  = 3'd2,
    ST_RD_D  = 3'd3,
    ST_RD_SS = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // One fifo entry: 128-bit stream word, 2-bit section, last flag.
  localparam int FIFO_W = 128 + 2 + 1;

  // Code length N for each parameter set.
  function automatic int hqc_n(input string ps);
    if (ps == "hqc128")      return 17669;
    else if (ps == "hqc192") return 35851;
    else                     return 57637;
  endfunction

  // N rounded up to whole 128-bit memory words (N_MEM / 128).
  function automatic int hqc_mem_words(input string ps);
    return (hqc_n(ps) + 127) / 128;
  endfunction

  function automatic logic [127:0] brev128(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127-8*k -: 8];
    return r;
  endfunction

  function automatic logic [31:0] brev32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/hqc_encap_out_streamer_fifo2.sv
// Two-entry fifo holding stream words (data, sect, last) between the read
// path and the output handshake. count_o feeds the read-credit check.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   push_i/wdata_i  write strobe and entry
//   pop_i           read strobe (head consumed)
//   rdata_o         head entry (registered storage, stable while not popped)
//   count_o         occupancy 0..2
// A push and a pop in the same cycle while full is legal; count is unchanged.
module hqc_out_fifo2
  import hqc_encap_out_streamer_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/hqc_encap_out_streamer.sv
// Reads a finished HQC encapsulation out of the joint design's encap_out
// port and emits it as one 128-bit handshaked frame: u, v, d, ss.
// Ports:
//   clk, rst (async active-low), start (sampled only in IDLE)
//   encap_out_type/en/addr  registered read request; encap_out returns
//                           the data one cycle after the strobe
//   out_data/out_sect/out_last/out_valid/out_ready  output stream
//   busy (not IDLE), done (one-cycle pulse after the final word is taken)
//   dbg_state               current FSM state
// Handshake: a word transfers on a cycle where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data/out_sect/out_last
// hold, and out_valid never drops until the word transfers.
// u/v words are byte-reversed; the last u and last v word have their
// PAD_BITS low bits cleared. d/ss reads give 32 bits each (top lane,
// byte-reversed); four reads pack into one word, first read lowest.
module hqc_encap_out_streamer
  import hqc_encap_out_streamer_pkg::*;
#(
  parameter string parameter_set = "hqc256",
  parameter int    U_WORDS       = hqc_mem_words(parameter_set),
  parameter int    V_WORDS       = U_WORDS,
  parameter int    PAD_BITS      = 88,
  parameter int    DSS_READS     = 16,
  parameter int    LOG_RAMDEPTH  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [1:0]              encap_out_type,
  output logic                    encap_out_en,
  output logic [LOG_RAMDEPTH-1:0] encap_out_addr,
  input  logic [127:0]            encap_out,
  output logic [127:0]            out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_sect,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output state_e                  dbg_state
);

  localparam int CW = LOG_RAMDEPTH + 1;
  localparam logic [CW-1:0] U_LEN   = CW'(U_WORDS);
  localparam logic [CW-1:0] V_LEN   = CW'(V_WORDS);
  localparam logic [CW-1:0] DSS_LEN = CW'(DSS_READS);
  localparam logic [127:0]  PAD_MASK = ~((128'd1 << PAD_BITS) - 128'd1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic                    en_q, en_d;
  logic [1:0]              type_q, type_d;
  logic [LOG_RAMDEPTH-1:0] addr_q, addr_d;

  // Read-return stage: marks the cycle encap_out carries valid data.
  logic       rv_q, rv_d;
  logic [1:0] rv_sect_q;
  logic       rv_last_q, rv_last_d;

  logic [95:0] pk_q;
  logic [1:0]  pk_cnt_q;
  logic        done_q, done_d;

  logic [CW-1:0] sect_len, type_len, last_cnt;
  logic [1:0]    inflight;
  logic          credit_ok;

  logic              fifo_push, fifo_pop;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  logic [1:0]        fifo_count;

  logic [127:0] uv_word;
  logic [31:0]  dss_word;
  logic         rv_is_uv;

  // Reads issued whose data has not yet landed in the fifo/packer.
  assign inflight  = {1'b0, en_q} + {1'b0, rv_q};
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < 3'd2;

  always_comb begin
    sect_len = DSS_LEN;
    case (state_q)
      ST_RD_U: sect_len = U_LEN;
      ST_RD_V: sect_len = V_LEN;
      default: sect_len = DSS_LEN;
    endcase
  end

  always_comb begin
    type_len = DSS_LEN;
    case (type_q)
      SECT_U:  type_len = U_LEN;
      SECT_V:  type_len = V_LEN;
      default: type_len = DSS_LEN;
    endcase
    last_cnt = type_len - CW'(1);
  end

  // Read sequencer. Each section waits for zero in-flight reads before
  // moving on, so encap_out_type never changes under an outstanding read.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    en_d     = 1'b0;
    addr_d   = addr_q;
    type_d   = type_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Fifo is empty in IDLE, so the first read needs no credit check.
          state_d  = ST_RD_U;
          type_d   = SECT_U;
          en_d     = 1'b1;
          addr_d   = '0;
          rd_cnt_d = CW'(1);
        end
      end
      ST_RD_U, ST_RD_V, ST_RD_D, ST_RD_SS: begin
        if (rd_cnt_q < sect_len) begin
          if (credit_ok) begin
            en_d     = 1'b1;
            addr_d   = rd_cnt_q[LOG_RAMDEPTH-1:0];
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end else if (inflight == 2'd0) begin
          rd_cnt_d = '0;
          addr_d   = '0;
          case (state_q)
            ST_RD_U: begin state_d = ST_RD_V;  type_d = SECT_V;  end
            ST_RD_V: begin state_d = ST_RD_D;  type_d = SECT_D;  end
            ST_RD_D: begin state_d = ST_RD_SS; type_d = SECT_SS; end
            default: begin state_d = ST_DRAIN; end
          endcase
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && (inflight == 2'd0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
      en_q     <= 1'b0;
      type_q   <= SECT_SS;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      en_q     <= en_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
    end
  end

  assign rv_d      = en_q;
  assign rv_last_d = en_q && ({1'b0, addr_q} == last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rv_q      <= 1'b0;
      rv_sect_q <= SECT_SS;
      rv_last_q <= 1'b0;
    end else begin
      rv_q      <= rv_d;
      rv_sect_q <= type_q;
      rv_last_q <= rv_last_d;
    end
  end

  // Return-data formatting. u (2) and v (3) both have bit 1 set.
  assign rv_is_uv = rv_sect_q[1];
  assign uv_word  = brev128(encap_out) & (rv_last_q ? PAD_MASK : {128{1'b1}});
  assign dss_word = brev32(encap_out[127:96]);

  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    if (rv_q) begin
      if (rv_is_uv) begin
        fifo_push  = 1'b1;
        fifo_wdata = {uv_word, rv_sect_q, 1'b0};
      end else if (pk_cnt_q == 2'd3) begin
        fifo_push  = 1'b1;
        fifo_wdata = {dss_word, pk_q, rv_sect_q,
                      rv_last_q && (rv_sect_q == SECT_SS)};
      end
    end
  end

  // d/ss packer: collects the first three 32-bit lanes of each word; the
  // fourth read completes the word straight into the fifo.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pk_q     <= '0;
      pk_cnt_q <= 2'd0;
    end else if (rv_q && !rv_is_uv) begin
      if (pk_cnt_q == 2'd3) begin
        pk_cnt_q <= 2'd0;
      end else begin
        pk_q[32*pk_cnt_q +: 32] <= dss_word;
        pk_cnt_q                <= pk_cnt_q + 2'd1;
      end
    end
  end

  hqc_out_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign fifo_pop  = out_valid && out_ready;
  assign out_data  = fifo_rdata[FIFO_W-1:3];
  assign out_sect  = fifo_rdata[2:1];
  assign out_last  = fifo_rdata[0];

  // done follows the cycle in which the frame's final word is accepted.
  assign done_d = fifo_pop && out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= done_d;
  end

  assign done           = done_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;
  assign encap_out_en   = en_q;
  assign encap_out_type = type_q;
  assign encap_out_addr = addr_q;

endmodule

// File: tb/tb_hqc_encap_out_streamer.sv
module tb_hqc_encap_out_streamer;
  import hqc_encap_out_streamer_pkg::*;

  localparam int UW    = 451;
  localparam int VW    = 451;
  localparam int TOTAL = UW + VW + 8;
  localparam int PAD   = 88;
  localparam int FW    = 131;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   encap_out_type;
  logic         encap_out_en;
  logic [8:0]   encap_out_addr;
  logic [127:0] encap_out = '0;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   out_sect;
  logic         out_last;
  logic         busy;
  logic         done;
  state_e       dbg_state;

  logic [FW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int last_acc_cyc = -100;
  bit ff_last    = 0;
  bit rand_ready = 0;
  bit first_d_seen = 0;
  logic [127:0] first_d_word = '0;
  bit prev_stall = 0;
  logic [FW-1:0] prev_word = '0;

  hqc_encap_out_streamer #(.parameter_set("hqc256")) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .encap_out_type (encap_out_type),
    .encap_out_en   (encap_out_en),
    .encap_out_addr (encap_out_addr),
    .encap_out      (encap_out),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sect       (out_sect),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory contents model ----------------
  function automatic logic [127:0] mem_word(input logic [1:0] t, input int a);
    logic [127:0] w;
    logic [7:0]   base;
    w = '0;
    if (t == SECT_U || t == SECT_V) begin
      if (ff_last && ((t == SECT_U && a == UW-1) || (t == SECT_V && a == VW-1)))
        w = {128{1'b1}};
      else
        for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(a + 17*k + 64*int'(t));
    end else begin
      base = (t == SECT_SS) ? 8'h80 : 8'h00;
      w[127:96] = {8'(base + 4*a + 3), 8'(base + 4*a + 2), 8'(base + 4*a + 1), 8'(base + 4*a)};
      w[95:0]   = 96'hDEADBEEF_CAFEF00D_12345678 ^ 96'(a);
    end
    return w;
  endfunction

  // Joint-design read port: data one cycle after the strobe.
  always @(posedge clk) begin
    if (encap_out_en) encap_out <= mem_word(encap_out_type, int'(encap_out_addr));
  end

  // ---------------- expected-value builders ----------------
  function automatic logic [127:0] exp_uv(input logic [1:0] t, input int a, input int n);
    logic [127:0] w, e;
    w = mem_word(t, a);
    e = '0;
    for (int k = 0; k < 16; k++) e[8*k +: 8] = w[127-8*k -: 8];
    if (a == n-1) e[PAD-1:0] = '0;
    return e;
  endfunction

  function automatic logic [127:0] exp_dss(input logic [1:0] t, input int j);
    logic [127:0] e;
    logic [7:0]   base;
    int a;
    base = (t == SECT_SS) ? 8'h80 : 8'h00;
    e = '0;
    for (int s = 0; s < 4; s++) begin
      a = 4*j + s;
      e[32*s +: 32] = {8'(base + 4*a), 8'(base + 4*a + 1), 8'(base + 4*a + 2), 8'(base + 4*a + 3)};
    end
    return e;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < UW; a++) exp_q.push_back({exp_uv(SECT_U, a, UW), SECT_U, 1'b0});
    for (int a = 0; a < VW; a++) exp_q.push_back({exp_uv(SECT_V, a, VW), SECT_V, 1'b0});
    for (int j = 0; j < 4; j++)  exp_q.push_back({exp_dss(SECT_D, j), SECT_D, 1'b0});
    for (int j = 0; j < 4; j++)  exp_q.push_back({exp_dss(SECT_SS, j), SECT_SS, (j == 3)});
  endtask

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- output-ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 9) >= 3);
    else            out_ready = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [FW-1:0] cur, e;
    cur = {out_data, out_sect, out_last};
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, prev_word});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", cur);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", cur, e);
        end
        if (out_sect == SECT_D && !first_d_seen) begin
          first_d_seen = 1;
          first_d_word = out_data;
        end
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_acc_cyc + 1);
        check("done_queue_empty", exp_q.size(), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input bit chk_timing);
    acc_cnt = 0;
    first_d_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (chk_timing) begin
      check("cyc1_en",   encap_out_en,   1);
      check("cyc1_type", encap_out_type, SECT_U);
      check("cyc1_addr", encap_out_addr, 0);
      check("cyc1_busy", busy,           1);
      @(posedge clk); #1;
      check("cyc2_valid", out_valid, 0);
      @(posedge clk); #1;
      check("cyc3_valid", out_valid, 1);
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 10000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_accepts"}, acc_cnt, TOTAL);
    check({name, "_done_count"}, done_cnt, d0 + 1);
    check({name, "_idle"}, {busy, out_valid}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {out_valid, busy, done, encap_out_en, encap_out_type, encap_out_addr, out_last}, 0);
    check("rst_data", out_data, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b1;

    // Frame 1: ready held high, cycle-accurate startup, d packing.
    build_expected();
    d0 = done_cnt;
    start_frame(1);
    wait_done(d0, "frame1");
    check("first_d_word", first_d_word, 128'h0C0D0E0F_08090A0B_04050607_00010203);

    // Frame 2: random backpressure, same stream expected.
    rand_ready = 1;
    build_expected();
    d0 = done_cnt;
    start_frame(0);
    wait_done(d0, "frame2");

    // Frame 3: last u/v words all ones -> padding bits cleared.
    ff_last = 1;
    build_expected();
    d0 = done_cnt;
    start_frame(0);
    wait_done(d0, "frame3");
    ff_last = 0;

    // Frame 4: abort at u word 200, then a full clean frame.
    rand_ready = 0;
    build_expected();
    d0 = done_cnt;
    start_frame(0);
    n = 0;
    while (acc_cnt < 200 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("abort_reached_200", acc_cnt >= 200, 1);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle", {out_valid, busy, done, encap_out_en}, 0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_no_done", done_cnt, d0);
    rst = 1'b1;
    build_expected();
    start_frame(1);
    wait_done(d0, "frame4");

    // Frame 5: start pulses while busy are ignored.
    rand_ready = 1;
    build_expected();
    d0 = done_cnt;
    start_frame(0);
    for (int p = 0; p < 4; p++) begin
      repeat ($urandom_range(20, 200)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(d0, "frame5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
